// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM MEM-stage SRAM bridge.
package arm_mem_pkg;

  // Controller phases: idle, low halfword access, high halfword access, completion
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  // Byte address that maps to SRAM halfword 0
  localparam int DATA_BASE = 1024;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times one halfword phase on the SRAM bus.
// o_tc is high while the count sits at zero (the last cycle of a phase).
module sram_wait_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_value,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  // Load takes priority; otherwise count down while enabled and not yet at zero
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);

endmodule

// File: rtl/sram_controller.sv
// Bridge from the ARM MEM stage to a 16-bit asynchronous SRAM.
// A 32-bit word access is split into two halfword accesses, low half first,
// while ready holds the pipeline.
// Optional single-entry read cache: define SRAM_CTRL_READ_CACHE_EN.
module sram_controller #(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 18,
  parameter int DATA_BASE     = arm_mem_pkg::DATA_BASE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MEM_W_EN,
  input  logic                        MEM_R_EN,
  input  logic [arm_mem_pkg::WORD_W-1:0] address,
  input  logic [arm_mem_pkg::WORD_W-1:0] storeValue,
  output logic [arm_mem_pkg::WORD_W-1:0] memoryData,
  output logic                        ready,
  output logic [SRAM_AW-1:0]          SRAM_ADDR,
  output logic [arm_mem_pkg::HALF_W-1:0] SRAM_DQ_OUT,
  input  logic [arm_mem_pkg::HALF_W-1:0] SRAM_DQ_IN,
  output logic                        SRAM_DQ_OE,
  output logic                        SRAM_WE_N
);
  import arm_mem_pkg::*;

  localparam int CW    = 4;
  localparam int WIX_W = SRAM_AW - 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(ACCESS_CYCLES - 1);

  sram_state_t r_state, w_state_next;

  // Request latched at acceptance
  logic              r_w_en, r_r_en;
  logic [WORD_W-1:0] r_addr, r_wdata;
  logic              w_w_en_next, w_r_en_next;
  logic [WORD_W-1:0] w_addr_next, w_wdata_next;

  // Registered outputs
  logic [WORD_W-1:0]  r_mem_data, w_mem_data_next;
  logic [SRAM_AW-1:0] r_sram_addr, w_sram_addr_next;
  logic [HALF_W-1:0]  r_dq_out, w_dq_out_next;
  logic               r_dq_oe, w_dq_oe_next;
  logic               r_we_n, w_we_n_next;

  logic              w_req, w_hit, w_is_write, w_is_read;
  logic              w_cnt_load, w_cnt_en, w_tc;
  logic [CW-1:0]     w_count;
  logic [WORD_W-1:0] w_int_in, w_int_lat;
  logic [WIX_W-1:0]  w_word_in, w_word_lat;
  logic              w_unused_bits;

  assign w_req      = MEM_W_EN | MEM_R_EN;
  assign w_is_write = r_w_en;
  assign w_is_read  = r_r_en & ~r_w_en;

  // Internal address wraps in 32 bits; the low two bits are dropped so every access is word aligned
  assign w_int_in   = address - WORD_W'(DATA_BASE);
  assign w_int_lat  = r_addr  - WORD_W'(DATA_BASE);
  assign w_word_in  = w_int_in[SRAM_AW:2];
  assign w_word_lat = w_int_lat[SRAM_AW:2];
  assign w_unused_bits = ^{w_int_in[WORD_W-1:SRAM_AW+1], w_int_in[1:0],
                           w_int_lat[WORD_W-1:SRAM_AW+1], w_int_lat[1:0]};

  sram_wait_counter #(
    .CW(CW)
  ) u_wait (
    .clk         (clk),
    .i_rst       (rst),
    .i_load      (w_cnt_load),
    .i_load_value(LOAD_VAL),
    .i_en        (w_cnt_en),
    .o_count     (w_count),
    .o_tc        (w_tc)
  );

`ifdef SRAM_CTRL_READ_CACHE_EN
  logic              r_c_valid;
  logic [WIX_W-1:0]  r_c_word;
  logic [WORD_W-1:0] r_c_data;

  assign w_hit = (r_state == IDLE) && MEM_R_EN && !MEM_W_EN && r_c_valid
                 && (r_c_word == w_word_in);

  // Fill on read completion; a write only refreshes the data when it targets the cached word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_word  <= '0;
      r_c_data  <= '0;
    end else if (r_state == DONE) begin
      if (w_is_read) begin
        r_c_valid <= 1'b1;
        r_c_word  <= w_word_lat;
        r_c_data  <= r_mem_data;
      end else if (w_word_lat == r_c_word) begin
        r_c_data  <= r_wdata;
      end
    end
  end

  assign memoryData = w_hit ? r_c_data : r_mem_data;
`else
  assign w_hit      = 1'b0;
  assign memoryData = r_mem_data;
`endif

  assign SRAM_ADDR   = r_sram_addr;
  assign SRAM_DQ_OUT = r_dq_out;
  assign SRAM_DQ_OE  = r_dq_oe;
  assign SRAM_WE_N   = r_we_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, ready, and the values the SRAM bus takes in the coming cycle
  always_comb begin
    w_state_next     = r_state;
    ready            = 1'b0;
    w_cnt_load       = 1'b0;
    w_cnt_en         = 1'b0;
    w_w_en_next      = r_w_en;
    w_r_en_next      = r_r_en;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_mem_data_next  = r_mem_data;
    w_sram_addr_next = r_sram_addr;
    w_dq_out_next    = r_dq_out;
    w_dq_oe_next     = r_dq_oe;
    w_we_n_next      = r_we_n;
    case (r_state)
      IDLE: begin
        ready = ~w_req | w_hit;
        if (w_req && !w_hit) begin
          w_state_next     = LOW;
          w_cnt_load       = 1'b1;
          w_w_en_next      = MEM_W_EN;
          w_r_en_next      = MEM_R_EN;
          w_addr_next      = address;
          w_wdata_next     = storeValue;
          w_sram_addr_next = {w_word_in, 1'b0};
          if (MEM_W_EN) begin
            w_dq_out_next = storeValue[HALF_W-1:0];
            w_dq_oe_next  = 1'b1;
            w_we_n_next   = 1'b0;
          end
        end
      end
      LOW, HIGH: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          if (w_is_read) begin
            if (r_state == LOW) w_mem_data_next[HALF_W-1:0]      = SRAM_DQ_IN;
            else                w_mem_data_next[WORD_W-1:HALF_W] = SRAM_DQ_IN;
          end
          if (r_state == LOW) begin
            w_state_next     = HIGH;
            w_cnt_load       = 1'b1;
            w_sram_addr_next = {w_word_lat, 1'b1};
            if (w_is_write) begin
              w_dq_out_next = r_wdata[WORD_W-1:HALF_W];
              w_dq_oe_next  = 1'b1;
              w_we_n_next   = 1'b0;
            end
          end else begin
            w_state_next = DONE;
            w_dq_oe_next = 1'b0;
            w_we_n_next  = 1'b1;
          end
        end else if (w_is_write) begin
          // Release the strobe one cycle before the phase ends so address/data hold past it
          w_we_n_next = (w_count == CW'(1));
        end
      end
      DONE: begin
        ready        = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Latched request and registered bus/data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_en      <= 1'b0;
      r_r_en      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_data  <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      r_w_en      <= w_w_en_next;
      r_r_en      <= w_r_en_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_mem_data  <= w_mem_data_next;
      r_sram_addr <= w_sram_addr_next;
      r_dq_out    <= w_dq_out_next;
      r_dq_oe     <= w_dq_oe_next;
      r_we_n      <= w_we_n_next;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural async SRAM model.
module tb_sram_controller;

  localparam int AC = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_W_EN, MEM_R_EN;
  logic [31:0]   address, storeValue, memoryData;
  logic          ready;
  logic [AW-1:0] SRAM_ADDR;
  logic [15:0]   SRAM_DQ_OUT, SRAM_DQ_IN;
  logic          SRAM_DQ_OE, SRAM_WE_N;

  int total = 0;
  int bad   = 0;

  sram_controller #(
    .ACCESS_CYCLES(AC),
    .SRAM_AW      (AW),
    .DATA_BASE    (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_W_EN   (MEM_W_EN),
    .MEM_R_EN   (MEM_R_EN),
    .address    (address),
    .storeValue (storeValue),
    .memoryData (memoryData),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_OUT(SRAM_DQ_OUT),
    .SRAM_DQ_IN (SRAM_DQ_IN),
    .SRAM_DQ_OE (SRAM_DQ_OE),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write on clock edges while strobed
  logic [15:0] sram [0:(1<<AW)-1];
  assign SRAM_DQ_IN = sram[SRAM_ADDR];
  always @(posedge clk) begin
    if (!SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR] <= SRAM_DQ_OUT;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction starting in an IDLE cycle; checks latency, strobe count, addresses and data
  task automatic run_txn(input string nm, input bit we, input bit re,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_md, input int exp_lat,
                         input int exp_wel, input int hw_lo, input bit chk_addr,
                         input bit drop);
    int lat;
    int wel;
    lat = -1;
    wel = 0;
    @(posedge clk); #1;
    MEM_W_EN = we; MEM_R_EN = re; address = addr; storeValue = wdata;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (!SRAM_WE_N) wel++;
      if (chk_addr && cyc == 1)      chk({nm, "_addr_lo"}, 32'(SRAM_ADDR), 32'(hw_lo));
      if (chk_addr && cyc == AC + 1) chk({nm, "_addr_hi"}, 32'(SRAM_ADDR), 32'(hw_lo + 1));
      if (drop && cyc == 1) begin
        MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; address = 32'h0; storeValue = 32'h0;
      end
      if (ready) begin
        lat = cyc;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_we_cycles"}, 32'(wel), 32'(exp_wel));
    chk({nm, "_mdata"}, memoryData, exp_md);
    $display("txn %s we=%0d re=%0d addr=%0d lat=%0d mdata=%h", nm, we, re, addr, lat, memoryData);
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_md;
    int          hw_lo;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] addr_before;
    vecs[0] = '{"wr_1028",   1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000, 2,       16'hBEEF, 16'hDEAD};
    vecs[1] = '{"rd_1028",   1'b0, 1'b1, 32'd1028, 32'h00000000, 32'hDEADBEEF, 2,       16'hBEEF, 16'hDEAD};
    vecs[2] = '{"both_1032", 1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 4,       16'h5678, 16'h1234};
    vecs[3] = '{"rd_1032",   1'b0, 1'b1, 32'd1032, 32'h00000000, 32'h12345678, 4,       16'h5678, 16'h1234};
    vecs[4] = '{"wr_1024",   1'b1, 1'b0, 32'd1024, 32'hA5A55A5A, 32'h12345678, 0,       16'h5A5A, 16'hA5A5};
    vecs[5] = '{"rd_1024",   1'b0, 1'b1, 32'd1024, 32'h00000000, 32'hA5A55A5A, 0,       16'h5A5A, 16'hA5A5};
    vecs[6] = '{"rd_1030",   1'b0, 1'b1, 32'd1030, 32'h00000000, 32'hDEADBEEF, 2,       16'hBEEF, 16'hDEAD};
    vecs[7] = '{"wr_1020",   1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, 32'hDEADBEEF, 'h3FFFE, 16'hC0DE, 16'h0BAD};
    vecs[8] = '{"rd_1020",   1'b0, 1'b1, 32'd1020, 32'h00000000, 32'h0BADC0DE, 'h3FFFE, 16'hC0DE, 16'h0BAD};

    rst = 1'b1; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; address = '0; storeValue = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready",  32'(ready),       32'd1);
    chk("reset_we_n",   32'(SRAM_WE_N),   32'd1);
    chk("reset_oe",     32'(SRAM_DQ_OE),  32'd0);
    chk("reset_mdata",  memoryData,       32'h0);
    chk("reset_addr",   32'(SRAM_ADDR),   32'h0);
    chk("reset_dq_out", 32'(SRAM_DQ_OUT), 32'h0);

    // Records run back to back: each starts in the IDLE cycle after the previous DONE
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_md, 5, vecs[i].we ? 2 : 0, vecs[i].hw_lo, 1'b1, 1'b0);
      chk({vecs[i].name, "_sram_lo"}, 32'(sram[vecs[i].hw_lo]),     32'(vecs[i].exp_lo));
      chk({vecs[i].name, "_sram_hi"}, 32'(sram[vecs[i].hw_lo + 1]), 32'(vecs[i].exp_hi));
    end

    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);

    // Reset while the high halfword of a write is being strobed
    @(posedge clk); #1;
    MEM_W_EN = 1'b1; address = 32'd1040; storeValue = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_high_strobe", 32'(SRAM_WE_N), 32'd0);
    rst = 1'b1; MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_we_n",  32'(SRAM_WE_N),  32'd1);
    chk("rst_mid_oe",    32'(SRAM_DQ_OE), 32'd0);
    chk("rst_mid_ready", 32'(ready),      32'd1);
    chk("rst_mid_mdata", memoryData,      32'h0);
    $display("txn rst_mid_write addr=1040 abandoned");
    run_txn("rd_after_rst", 1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 5, 0, 2, 1'b1, 1'b0);

    // Request dropped right after acceptance still completes
    run_txn("rd_drop_1032", 1'b0, 1'b1, 32'd1032, 32'h0, 32'h12345678, 5, 0, 4, 1'b1, 1'b1);

`ifdef SRAM_CTRL_READ_CACHE_EN
    run_txn("c_wr_1036", 1'b1, 1'b0, 32'd1036, 32'h0F0F1E1E, 32'h12345678, 5, 2, 6, 1'b1, 1'b0);
    run_txn("c_rd_miss", 1'b0, 1'b1, 32'd1036, 32'h0, 32'h0F0F1E1E, 5, 0, 6, 1'b1, 1'b0);
    addr_before = SRAM_ADDR;
    run_txn("c_rd_hit",  1'b0, 1'b1, 32'd1036, 32'h0, 32'h0F0F1E1E, 0, 0, 6, 1'b0, 1'b0);
    chk("c_hit_addr_still", 32'(SRAM_ADDR), 32'(addr_before));
    run_txn("c_wr_new",  1'b1, 1'b0, 32'd1036, 32'h77778888, 32'h0F0F1E1E, 5, 2, 6, 1'b1, 1'b0);
    run_txn("c_rd_new",  1'b0, 1'b1, 32'd1036, 32'h0, 32'h77778888, 0, 0, 6, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
